// File: rtl/kl8e_tty_if.sv
// KL8E console bus bundle: CPU IOT strobe/data lines plus the UART
// transmit and receive req/ack handshakes, seen from the controller (slave)
// and from whatever drives it (master: CPU and UART side).
interface kl8e_tty_if;
  // CPU IOT bus
  logic        iot;
  logic [5:0]  io_select;
  logic [2:0]  io_op;
  logic [11:0] io_data_in;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_clear_ac;
  logic        io_skip;
  logic        io_interrupt;
  // UART transmit side
  logic        tx_req;
  logic        tx_ack;
  logic [7:0]  tx_data;
  logic        tx_empty;
  // UART receive side
  logic        rx_req;
  logic        rx_ack;
  logic        rx_empty;
  logic [7:0]  rx_data;

  modport slave (
    input  iot, io_select, io_op, io_data_in,
    input  tx_ack, tx_empty, rx_ack, rx_empty, rx_data,
    output io_data_out, io_data_avail, io_clear_ac, io_skip, io_interrupt,
    output tx_req, tx_data, rx_req
  );

  modport master (
    output iot, io_select, io_op, io_data_in,
    output tx_ack, tx_empty, rx_ack, rx_empty, rx_data,
    input  io_data_out, io_data_avail, io_clear_ac, io_skip, io_interrupt,
    input  tx_req, tx_data, rx_req
  );
endinterface

// File: rtl/kl8e_tty.sv
// PDP-8 KL8E console teletype controller. Decodes keyboard and teleprinter
// IOTs, owns both device flags, the keyboard and printer buffers and the
// interrupt enable, and runs the UART receive/transmit req/ack handshakes.
module kl8e_tty #(
  parameter logic [5:0] KBD_DEV       = 6'o03,
  parameter logic [5:0] TTY_DEV       = 6'o04,
  parameter logic       INT_ENA_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  kl8e_tty_if.slave  bus
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY, T_WAIT} tx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;

  logic        kbd_flag_q, kbd_flag_d;
  logic        tty_flag_q, tty_flag_d;
  logic        int_ena_q,  int_ena_d;
  logic [7:0]  kbd_buf_q,  kbd_buf_d;
  logic [7:0]  tty_buf_q,  tty_buf_d;

  // IOT decode results
  logic        kbd_sel, tty_sel;
  logic        kbd_clr, kie_wr;
  logic        tfl_set, tcf_clr, tpc;
  logic [11:0] data_out;
  logic        data_avail, clear_ac, skip;

  // FSM side effects
  logic        rx_req, kbd_load;
  logic        tx_req, tty_load, tty_done;

  // Only the low AC bits ever reach a device register.
  logic        unused_ac_hi;
  assign unused_ac_hi = ^bus.io_data_in[11:8];

  // IOT decode: combinational responses to the CPU plus register-update strobes
  always_comb begin
    kbd_sel    = bus.iot && (bus.io_select == KBD_DEV);
    tty_sel    = bus.iot && (bus.io_select == TTY_DEV);
    kbd_clr    = 1'b0;
    kie_wr     = 1'b0;
    tfl_set    = 1'b0;
    tcf_clr    = 1'b0;
    tpc        = 1'b0;
    data_out   = 12'o0000;
    data_avail = 1'b0;
    clear_ac   = 1'b0;
    skip       = 1'b0;
    if (kbd_sel) begin
      unique case (bus.io_op)
        3'o0: kbd_clr = 1'b1;                                   // KCF
        3'o1: skip    = kbd_flag_q;                             // KSF
        3'o2: begin kbd_clr = 1'b1; clear_ac = 1'b1; end        // KCC
        3'o4: begin data_out = {4'b0, kbd_buf_q}; data_avail = 1'b1; end  // KRS
        3'o5: kie_wr  = 1'b1;                                   // KIE
        3'o6: begin                                             // KRB
          kbd_clr    = 1'b1;
          clear_ac   = 1'b1;
          data_out   = {4'b0, kbd_buf_q};
          data_avail = 1'b1;
        end
        default: ;
      endcase
    end
    if (tty_sel) begin
      unique case (bus.io_op)
        3'o0: tfl_set = 1'b1;                                   // TFL
        3'o1: skip    = tty_flag_q;                             // TSF
        3'o2: tcf_clr = 1'b1;                                   // TCF
        3'o4: tpc     = 1'b1;                                   // TPC
        3'o5: skip    = tty_flag_q | kbd_flag_q;                // TSK
        3'o6: begin tcf_clr = 1'b1; tpc = 1'b1; end             // TLS
        default: ;
      endcase
    end
  end

  // Receive FSM: fetch a character only when the buffer is free and the
  // CPU is not touching the keyboard this cycle
  always_comb begin
    rx_state_d = rx_state_q;
    rx_req     = 1'b0;
    kbd_load   = 1'b0;
    unique case (rx_state_q)
      R_IDLE: if (!bus.rx_empty && !kbd_flag_q && !kbd_sel) rx_state_d = R_REQ;
      R_REQ: begin
        rx_req = 1'b1;
        if (bus.rx_ack) rx_state_d = R_CAP;
      end
      R_CAP: begin
        kbd_load   = 1'b1;
        rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Transmit FSM: a TPC outside T_IDLE is dropped; T_BUSY blanks tx_empty
  // for one clock so a stale idle indication is not taken as completion
  always_comb begin
    tx_state_d = tx_state_q;
    tx_req     = 1'b0;
    tty_load   = 1'b0;
    tty_done   = 1'b0;
    unique case (tx_state_q)
      T_IDLE: if (tpc) begin
        tty_load   = 1'b1;
        tx_state_d = T_REQ;
      end
      T_REQ: begin
        tx_req = 1'b1;
        if (bus.tx_ack) tx_state_d = T_BUSY;
      end
      T_BUSY: tx_state_d = T_WAIT;
      T_WAIT: if (bus.tx_empty) begin
        tty_done   = 1'b1;
        tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Flag and buffer next state; an IOT clear beats a same-cycle hardware set
  always_comb begin
    kbd_flag_d = kbd_flag_q;
    if (kbd_load) kbd_flag_d = 1'b1;
    if (kbd_clr)  kbd_flag_d = 1'b0;
    tty_flag_d = tty_flag_q;
    if (tty_done || tfl_set) tty_flag_d = 1'b1;
    if (tcf_clr)             tty_flag_d = 1'b0;
    int_ena_d  = kie_wr   ? bus.io_data_in[0]   : int_ena_q;
    kbd_buf_d  = kbd_load ? bus.rx_data         : kbd_buf_q;
    tty_buf_d  = tty_load ? bus.io_data_in[7:0] : tty_buf_q;
  end

  // State register; reset also aborts any handshake in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      kbd_flag_q <= 1'b0;
      tty_flag_q <= 1'b0;
      int_ena_q  <= INT_ENA_RESET;
      kbd_buf_q  <= 8'h00;
      tty_buf_q  <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      kbd_flag_q <= kbd_flag_d;
      tty_flag_q <= tty_flag_d;
      int_ena_q  <= int_ena_d;
      kbd_buf_q  <= kbd_buf_d;
      tty_buf_q  <= tty_buf_d;
    end
  end

  assign bus.io_data_out   = data_out;
  assign bus.io_data_avail = data_avail;
  assign bus.io_clear_ac   = clear_ac;
  assign bus.io_skip       = skip;
  assign bus.io_interrupt  = int_ena_q & (kbd_flag_q | tty_flag_q);
  assign bus.tx_req        = tx_req;
  assign bus.tx_data       = tty_buf_q;
  assign bus.rx_req        = rx_req;

endmodule
